// File: rtl/db_log_pkg.sv
// Shared types and constants for the pipelined dB converter.
// The log2 mantissa table is built by a constant function during elaboration.
package db_log_pkg;

  typedef enum logic {DB_PWR = 1'b0, DB_AMP = 1'b1} db_mode_e;

  // dB-per-octave scale factors, unsigned with K_FRAC fractional bits
  localparam int K_FRAC = 28;
  localparam int K_W    = 32;
  localparam logic [K_W-1:0] K10_Q = 32'd808071242;   // 10*log10(2)
  localparam logic [K_W-1:0] K20_Q = 32'd1616142483;  // 20*log10(2)

  // Entry idx of a (2^lut_addr + 1)-entry table of log2(1 + idx/2^lut_addr),
  // frac_bits fractional bits, computed by repeated squaring in Q2.62.
  function automatic logic [63:0] build_log2_lut(input int lut_addr, input int idx,
                                                 input int frac_bits);
    logic [127:0] y;
    logic [63:0]  res;
    res = '0;
    if (idx >= (1 << lut_addr)) begin
      res = 64'(1) << frac_bits;
    end else begin
      y = (128'(1) << 62) + (128'(idx) << (62 - lut_addr));
      for (int b = 0; b < frac_bits; b++) begin
        y   = (y * y) >> 62;
        res = res << 1;
        if (y >= (128'(1) << 63)) begin
          res[0] = 1'b1;
          y      = y >> 1;
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/db_lzc.sv
// Combinational leading-zero counter with an all-zero flag.
module db_lzc #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]         data_i,
  output logic [$clog2(WIDTH)-1:0] lz_cnt_o,
  output logic                     zero_o
);

  localparam int CW = $clog2(WIDTH);

  // Highest set bit wins because it is visited last.
  always_comb begin
    lz_cnt_o = '0;
    zero_o   = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      if (data_i[i]) begin
        lz_cnt_o = CW'(WIDTH - 1 - i);
        zero_o   = 1'b0;
      end
    end
  end

endmodule

// File: rtl/db_log_pipe.sv
// Four-stage streaming converter from unsigned power/amplitude to signed dB,
// with channel tag, valid/ready backpressure and saturation flags.
module db_log_pipe
  import db_log_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int IN_FRAC  = 0,
  parameter int OUT_W    = 32,
  parameter int OUT_FRAC = 24,
  parameter int LUT_ADDR = 6,
  parameter int NCH      = 4,
  localparam int CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             enable_in,
  output logic             ready_out,
  input  logic [WIDTH-1:0] data_in,
  input  logic [CH_W-1:0]  chan_in,
  input  logic             mode_in,
  output logic             valid_out,
  input  logic             ready_in,
  output logic [OUT_W-1:0] log_out,
  output logic [CH_W-1:0]  chan_out,
  output logic             zero_out,
  output logic             sat_out
);

  localparam int FB    = OUT_FRAC + 4;
  localparam int LW    = FB + 1;
  localparam int LUT_N = (1 << LUT_ADDR) + 1;
  localparam int IW    = ((WIDTH - 1 - LUT_ADDR) > 16) ? 16 : (WIDTH - 1 - LUT_ADDR);
  localparam int CW    = $clog2(WIDTH);
  localparam int EW    = $clog2(WIDTH + IN_FRAC + 1) + 1;
  localparam int L2_W  = EW + FB + 1;
  localparam int PW    = L2_W + K_W + 1;
  localparam int SH    = FB + K_FRAC - OUT_FRAC;
  localparam int E_OFF = WIDTH - 1 - IN_FRAC;

  localparam logic signed [PW-1:0] RND_HALF = {{(PW-SH){1'b0}}, 1'b1, {(SH-1){1'b0}}};
  localparam logic signed [PW-1:0] OMAX     = PW'({1'b0, {(OUT_W-1){1'b1}}});
  localparam logic signed [PW-1:0] OMIN     = ~OMAX;
  localparam logic [OUT_W-1:0]     MOST_NEG = {1'b1, {(OUT_W-1){1'b0}}};

  logic advance;
  assign advance   = ~valid_out | ready_in;
  assign ready_out = advance;

  logic [LW-1:0] lut [LUT_N];
  for (genvar gi = 0; gi < LUT_N; gi++) begin : g_lut
    localparam logic [63:0] ENTRY = build_log2_lut(LUT_ADDR, gi, FB);
    assign lut[gi] = ENTRY[LW-1:0];
  end

  logic                           s1_vld_q, s2_vld_q, s3_vld_q;
  logic [WIDTH-1:0]               s1_data_q;
  logic [CH_W-1:0]                s1_chan_q, s2_chan_q, s3_chan_q;
  db_mode_e                       s1_mode_q, s2_mode_q, s3_mode_q;
  logic                           s2_zero_q, s3_zero_q;
  logic signed [EW-1:0]           s2_exp_q;
  logic [LUT_ADDR+IW-1:0]         s2_frac_q;
  logic signed [L2_W-1:0]         s3_l2_q;
  logic                           valid_q, zero_q, sat_q;
  logic [OUT_W-1:0]               log_q;
  logic [CH_W-1:0]                chan_q;

  // S2: normalise so the leading one sits at the top bit.
  logic [CW-1:0]          lz_cnt;
  logic                   lz_zero;
  logic [WIDTH-1:0]       norm;
  logic signed [EW-1:0]   exp_d;
  logic [LUT_ADDR+IW-1:0] frac_d;

  db_lzc #(.WIDTH(WIDTH)) u_lzc (
    .data_i   (s1_data_q),
    .lz_cnt_o (lz_cnt),
    .zero_o   (lz_zero)
  );

  assign norm   = s1_data_q << lz_cnt;
  assign exp_d  = EW'(E_OFF) - EW'(lz_cnt);
  assign frac_d = norm[WIDTH-2 -: (LUT_ADDR + IW)];

  // S3: table lookup with linear interpolation on the remaining fraction bits.
  logic [LUT_ADDR:0]      idx_lo, idx_hi;
  logic [IW-1:0]          t_frac;
  logic [LW-1:0]          lut_lo, lut_hi, frac_l2;
  logic [LW+IW-1:0]       prod_it;
  logic signed [L2_W-1:0] l2_d;

  assign idx_lo  = {1'b0, s2_frac_q[LUT_ADDR+IW-1 -: LUT_ADDR]};
  assign idx_hi  = idx_lo + 1'b1;
  assign t_frac  = s2_frac_q[IW-1:0];
  assign lut_lo  = lut[idx_lo];
  assign lut_hi  = lut[idx_hi];
  assign prod_it = (LW+IW)'(lut_hi - lut_lo) * (LW+IW)'(t_frac);
  assign frac_l2 = lut_lo + prod_it[IW +: LW];
  assign l2_d    = (L2_W'(s2_exp_q) <<< FB) + $signed(L2_W'(frac_l2));

  logic unused_bits;
  assign unused_bits = ^{norm << (LUT_ADDR + IW + 1), prod_it[IW-1:0]};

  // S4: scale to dB, round half-up, clip to the output range.
  logic [K_W-1:0]       k_sel;
  logic signed [PW-1:0] prod, rnd, scaled;
  logic [OUT_W-1:0]     log_d;
  logic                 zero_d, sat_d;

  assign k_sel  = (s3_mode_q == DB_AMP) ? K20_Q : K10_Q;
  assign prod   = PW'(s3_l2_q) * PW'($signed({1'b0, k_sel}));
  assign rnd    = prod + RND_HALF;
  assign scaled = rnd >>> SH;

  always_comb begin
    log_d  = scaled[OUT_W-1:0];
    zero_d = 1'b0;
    sat_d  = 1'b0;
    if (s3_zero_q) begin
      log_d  = MOST_NEG;
      zero_d = 1'b1;
    end else if (scaled > OMAX) begin
      log_d = OMAX[OUT_W-1:0];
      sat_d = 1'b1;
    end else if (scaled < OMIN) begin
      log_d = OMIN[OUT_W-1:0];
      sat_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_vld_q  <= 1'b0;  s1_data_q <= '0;  s1_chan_q <= '0;  s1_mode_q <= DB_PWR;
      s2_vld_q  <= 1'b0;  s2_zero_q <= 1'b0; s2_exp_q <= '0;  s2_frac_q <= '0;
      s2_chan_q <= '0;    s2_mode_q <= DB_PWR;
      s3_vld_q  <= 1'b0;  s3_zero_q <= 1'b0; s3_l2_q  <= '0;  s3_chan_q <= '0;
      s3_mode_q <= DB_PWR;
      valid_q   <= 1'b0;  log_q     <= '0;  chan_q    <= '0;  zero_q    <= 1'b0;
      sat_q     <= 1'b0;
    end else if (advance) begin
      s1_vld_q  <= enable_in;
      s1_data_q <= data_in;
      s1_chan_q <= chan_in;
      s1_mode_q <= db_mode_e'(mode_in);
      s2_vld_q  <= s1_vld_q;
      s2_zero_q <= lz_zero;
      s2_exp_q  <= exp_d;
      s2_frac_q <= frac_d;
      s2_chan_q <= s1_chan_q;
      s2_mode_q <= s1_mode_q;
      s3_vld_q  <= s2_vld_q;
      s3_zero_q <= s2_zero_q;
      s3_l2_q   <= l2_d;
      s3_chan_q <= s2_chan_q;
      s3_mode_q <= s2_mode_q;
      valid_q   <= s3_vld_q;
      log_q     <= log_d;
      chan_q    <= s3_chan_q;
      zero_q    <= zero_d;
      sat_q     <= sat_d;
    end
  end

  assign valid_out = valid_q;
  assign log_out   = log_q;
  assign chan_out  = chan_q;
  assign zero_out  = zero_q;
  assign sat_out   = sat_q;

endmodule
